dphy_lane_tx: RTL

Transmit-side D-PHY data-lane sequencer for the CSI-2 link, the counterpart of the receive-side byte aligner. It takes packet bytes from the link-layer packer over a valid/ready stream and drives one lane's LP line states and HS byte stream to the serializer. Each burst runs LP-11 → LP-01 → LP-00 → HS-zero leader → sync byte 0xB8 → payload → HS trailer → exit. Payload bits are serialized LSB first downstream.

---
 rtl/dphy_lane_tx_if.sv | 15 +
 rtl/dphy_lane_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dphy_lane_tx_if.sv
// Byte stream from the link-layer packer into the D-PHY lane transmitter.
//   tx_data  : payload byte
//   tx_valid : tx_data holds a byte
//   tx_last  : this byte ends the burst
//   tx_ready : the lane takes the byte on an edge where tx_valid & tx_ready
// master = packer side, slave = lane transmitter side.
interface dphy_lane_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/dphy_lane_tx.sv
// Transmit-side D-PHY data-lane sequencer. One burst runs
//   LP-11 -> LP-01 -> LP-00 -> HS zero leader -> 0xB8 sync -> payload
//   -> HS trailer -> LP-11 exit hold
// Ports:
//   clk_i, rst_n_i : byte clock, asynchronous active-low reset
//   tx             : payload byte stream (slave side)
//   hs_en_o        : HS driver enable
//   hs_byte_o      : byte to the serializer (sent LSB first downstream)
//   lp_p_o, lp_n_o : LP line states of Dp / Dn
//   underflow_o    : one-cycle pulse in the first trailer cycle of a burst
//                    cut short because the source stalled
// Every output is a flop that shows the state occupied in the same cycle.
module dphy_lane_tx #(
    parameter int LPX_CYCLES        = 2,
    parameter int HS_PREPARE_CYCLES = 2,
    parameter int HS_ZERO_BYTES     = 6,
    parameter int HS_TRAIL_BYTES    = 4,
    parameter int HS_EXIT_CYCLES    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    dphy_lane_tx_if.slave        tx,
    output logic                 hs_en_o,
    output logic [7:0]           hs_byte_o,
    output logic                 lp_p_o,
    output logic                 lp_n_o,
    output logic                 underflow_o
);
    localparam int MAX_AB  = (LPX_CYCLES > HS_PREPARE_CYCLES) ? LPX_CYCLES : HS_PREPARE_CYCLES;
    localparam int MAX_CD  = (HS_ZERO_BYTES > HS_TRAIL_BYTES) ? HS_ZERO_BYTES : HS_TRAIL_BYTES;
    localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_CNT = (MAX_ABCD > HS_EXIT_CYCLES) ? MAX_ABCD : HS_EXIT_CYCLES;
    // The counter holds N-1 for an N-cycle state.
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        LP_IDLE, LP_RQST, LP_BRIDGE, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [7:0]       byte_q, byte_d;
    logic [1:0]       lp_q, lp_d;
    logic             hs_en_q, hs_en_d;
    logic             ready_q, ready_d;
    logic             uflow_q, uflow_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        byte_d  = byte_q;
        uflow_d = 1'b0;

        case (state_q)
            LP_IDLE: begin
                if (tx.tx_valid) begin
                    state_d = LP_RQST;
                    cnt_d   = CNT_W'(LPX_CYCLES - 1);
                end
            end
            LP_RQST: begin
                if (cnt_zero) begin
                    state_d = LP_BRIDGE;
                    cnt_d   = CNT_W'(HS_PREPARE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LP_BRIDGE: begin
                if (cnt_zero) begin
                    state_d = HS_ZERO;
                    cnt_d   = CNT_W'(HS_ZERO_BYTES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HS_ZERO: begin
                if (cnt_zero) begin
                    state_d = HS_SYNC;
                    byte_d  = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HS_SYNC, HS_DATA: begin
                if (ready_q && tx.tx_valid) begin
                    state_d = HS_DATA;
                    byte_d  = tx.tx_data;
                    done_d  = tx.tx_last;
                end else begin
                    // Either the last byte has just been shown (ready low) or
                    // the source stalled while we were asking for data (ready
                    // high): both end the burst, only the second is an underflow.
                    // The trailer is the inverse of the last emitted bit 7.
                    state_d = HS_TRAIL;
                    cnt_d   = CNT_W'(HS_TRAIL_BYTES - 1);
                    byte_d  = byte_q[7] ? 8'h00 : 8'hFF;
                    done_d  = 1'b0;
                    uflow_d = ready_q;
                end
            end
            HS_TRAIL: begin
                if (cnt_zero) begin
                    state_d = HS_EXIT;
                    cnt_d   = CNT_W'(HS_EXIT_CYCLES - 1);
                    byte_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HS_EXIT: begin
                if (cnt_zero) begin
                    state_d = LP_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = LP_IDLE;
                cnt_d   = '0;
                done_d  = 1'b0;
                byte_d  = 8'h00;
            end
        endcase

        // Line outputs are decoded from the next state so the flops show the
        // state being entered, not the one being left.
        lp_d    = 2'b00;
        hs_en_d = 1'b0;
        case (state_d)
            LP_IDLE, HS_EXIT: lp_d = 2'b11;
            LP_RQST:          lp_d = 2'b01;
            LP_BRIDGE:        lp_d = 2'b00;
            default:          hs_en_d = 1'b1;
        endcase
        ready_d = ((state_d == HS_SYNC) || (state_d == HS_DATA)) && !done_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LP_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            byte_q  <= 8'h00;
            lp_q    <= 2'b11;
            hs_en_q <= 1'b0;
            ready_q <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
            lp_q    <= lp_d;
            hs_en_q <= hs_en_d;
            ready_q <= ready_d;
            uflow_q <= uflow_d;
        end
    end

    assign tx.tx_ready = ready_q;
    assign hs_en_o     = hs_en_q;
    assign hs_byte_o   = byte_q;
    assign lp_p_o      = lp_q[1];
    assign lp_n_o      = lp_q[0];
    assign underflow_o = uflow_q;
endmodule
